mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_if.sv | 58 +++++
 rtl/mem_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the three requester ports, the DDR2 command/write-data FIFOs
// and the read-return path. The arbiter takes the slave view; whatever
// drives requests and models the memory controller takes the master view.
interface mem_req_arbiter_if;
    logic         px_req;
    logic [27:0]  px_addr;
    logic         px_ack;

    logic         c_req;
    logic         c_we;
    logic [27:0]  c_addr;
    logic [255:0] c_din;
    logic [31:0]  c_mask;
    logic         c_ack;

    logic         g_req;
    logic [27:0]  g_addr;
    logic [255:0] g_din;
    logic [31:0]  g_mask;
    logic         g_ack;

    logic         af_full;
    logic         af_wr_en;
    logic [30:0]  af_addr_din;

    logic         wdf_full;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    logic         rdf_valid;
    logic [127:0] rdf_dout;
    logic [127:0] rd_data;
    logic         px_rd_valid;
    logic         c_rd_valid;

    modport slave (
        input  px_req, px_addr,
        input  c_req, c_we, c_addr, c_din, c_mask,
        input  g_req, g_addr, g_din, g_mask,
        input  af_full, wdf_full, rdf_valid, rdf_dout,
        output px_ack, c_ack, g_ack,
        output af_wr_en, af_addr_din,
        output wdf_wr_en, wdf_din, wdf_mask_din,
        output rd_data, px_rd_valid, c_rd_valid
    );

    modport master (
        output px_req, px_addr,
        output c_req, c_we, c_addr, c_din, c_mask,
        output g_req, g_addr, g_din, g_mask,
        output af_full, wdf_full, rdf_valid, rdf_dout,
        input  px_ack, c_ack, g_ack,
        input  af_wr_en, af_addr_din,
        input  wdf_wr_en, wdf_din, wdf_mask_din,
        input  rd_data, px_rd_valid, c_rd_valid
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates pixel-feeder reads, cache reads/writes and graphics writes onto
// a DDR2 controller. Writes are 256 bits split into two 128-bit beats; reads
// are tagged so the two returning beats can be routed to the right requester.
// The graphics requester gets promoted once it has waited STARVE_LIMIT cycles.
module mem_req_arbiter #(
    parameter int TAG_DEPTH    = 16,
    parameter int STARVE_LIMIT = 32
) (
    input  logic             cpu_clk_g,
    input  logic             rst,
    mem_req_arbiter_if.slave bus,
    output logic             tag_err_o
);
    localparam int PW = $clog2(TAG_DEPTH);

    typedef enum logic {IDLE, WR2} state_t;

    state_t        state_q, state_d;
    logic [127:0]  upperBeat_q, upperBeat_d;
    logic [15:0]   upperMask_q, upperMask_d;
    logic [5:0]    waitCnt_q, waitCnt_d;
    logic          tagMem_q [TAG_DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [PW:0]   tagCount_q;
    logic          beat_q;
    logic          err_q;

    logic tagFull, tagEmpty, readOk, writeOk, starved;
    logic pxElig, cElig, gElig;
    logic grantPx, grantC, grantG, grantRead, grantWrite;
    logic validBeat, headTag, tagPush, tagPop;

    // Pick at most one winner per cycle; a starved gfx request overrides px > c > g
    always_comb begin
        tagFull    = (tagCount_q == (PW+1)'(TAG_DEPTH));
        tagEmpty   = (tagCount_q == '0);
        readOk     = !bus.af_full && !tagFull;
        writeOk    = !bus.af_full && !bus.wdf_full;
        starved    = 32'(waitCnt_q) >= 32'(STARVE_LIMIT);
        pxElig     = bus.px_req && readOk;
        cElig      = bus.c_req && (bus.c_we ? writeOk : readOk);
        gElig      = bus.g_req && writeOk;
        grantPx    = 1'b0;
        grantC     = 1'b0;
        grantG     = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (starved && gElig)  grantG  = 1'b1;
            else if (pxElig)       grantPx = 1'b1;
            else if (cElig)        grantC  = 1'b1;
            else if (gElig)        grantG  = 1'b1;
        end
        grantRead  = grantPx || (grantC && !bus.c_we);
        grantWrite = grantG || (grantC && bus.c_we);
        if (bus.g_req && !grantG)
            waitCnt_d = (waitCnt_q == 6'h3f) ? waitCnt_q : waitCnt_q + 6'd1;
        else
            waitCnt_d = '0;
    end

    // Drive acks and the DDR2 FIFOs, and move between the first and second write beat
    always_comb begin
        state_d          = state_q;
        upperBeat_d      = upperBeat_q;
        upperMask_d      = upperMask_q;
        bus.px_ack       = grantPx;
        bus.c_ack        = grantC;
        bus.g_ack        = grantG;
        bus.af_wr_en     = grantRead || grantWrite;
        bus.af_addr_din  = '0;
        bus.wdf_wr_en    = 1'b0;
        bus.wdf_din      = '0;
        bus.wdf_mask_din = '0;
        if (grantPx)
            bus.af_addr_din = {3'b001, bus.px_addr};
        else if (grantC)
            bus.af_addr_din = {(bus.c_we ? 3'b000 : 3'b001), bus.c_addr};
        else if (grantG)
            bus.af_addr_din = {3'b000, bus.g_addr};
        case (state_q)
            IDLE: begin
                if (grantWrite) begin
                    bus.wdf_wr_en = 1'b1;
                    state_d       = WR2;
                    if (grantG) begin
                        bus.wdf_din      = bus.g_din[127:0];
                        bus.wdf_mask_din = bus.g_mask[15:0];
                        upperBeat_d      = bus.g_din[255:128];
                        upperMask_d      = bus.g_mask[31:16];
                    end else begin
                        bus.wdf_din      = bus.c_din[127:0];
                        bus.wdf_mask_din = bus.c_mask[15:0];
                        upperBeat_d      = bus.c_din[255:128];
                        upperMask_d      = bus.c_mask[31:16];
                    end
                end
            end
            WR2: begin
                bus.wdf_din      = upperBeat_q;
                bus.wdf_mask_din = upperMask_q;
                if (!rst && !bus.wdf_full) begin
                    bus.wdf_wr_en = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Route returning read beats by the oldest outstanding tag; second beat retires it
    always_comb begin
        validBeat       = bus.rdf_valid && !tagEmpty && !rst;
        headTag         = tagMem_q[rdPtr_q];
        bus.px_rd_valid = validBeat && !headTag;
        bus.c_rd_valid  = validBeat && headTag;
        bus.rd_data     = bus.rdf_dout;
        tagPush         = grantRead;
        tagPop          = validBeat && beat_q;
    end

    // Tag storage needs no reset: the pointers and count decide what is valid
    always_ff @(posedge cpu_clk_g) begin
        if (tagPush)
            tagMem_q[wrPtr_q] <= grantC;
    end

    // State, latched upper beat, starvation counter, tag pointers and error flag
    always_ff @(posedge cpu_clk_g) begin
        if (rst) begin
            state_q     <= IDLE;
            upperBeat_q <= '0;
            upperMask_q <= '0;
            waitCnt_q   <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            tagCount_q  <= '0;
            beat_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            upperBeat_q <= upperBeat_d;
            upperMask_q <= upperMask_d;
            waitCnt_q   <= waitCnt_d;
            if (tagPush)
                wrPtr_q <= wrPtr_q + PW'(1);
            if (tagPop)
                rdPtr_q <= rdPtr_q + PW'(1);
            case ({tagPush, tagPop})
                2'b10:   tagCount_q <= tagCount_q + (PW+1)'(1);
                2'b01:   tagCount_q <= tagCount_q - (PW+1)'(1);
                default: tagCount_q <= tagCount_q;
            endcase
            if (validBeat)
                beat_q <= ~beat_q;
            if (bus.rdf_valid && tagEmpty)
                err_q <= 1'b1;
        end
    end

    assign tag_err_o = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the arbitration rules.
module tb_mem_req_arbiter;
    localparam int TAG_DEPTH    = 16;
    localparam int STARVE_LIMIT = 32;

    logic cpu_clk_g = 1'b0;
    logic rst;
    logic tagErr;

    int total = 0;
    int bad   = 0;

    // Model state: outstanding read tags (0=px, 1=c), beat parity, pending upper beat
    bit           tagQ[$];
    bit           beatM;
    bit           wr2M;
    bit           errM;
    logic [127:0] upperM;
    logic [15:0]  upperMaskM;
    int           waitM;

    // What the DUT did in the cycle just checked
    int ackWho;
    bit lastAf, lastWdf, lastPxV, lastCV;

    // Requester keeps a new request up right after its ack
    bit pxAgain, cAgain, gAgain;

    mem_req_arbiter_if bus ();

    mem_req_arbiter #(
        .TAG_DEPTH   (TAG_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .cpu_clk_g(cpu_clk_g),
        .rst      (rst),
        .bus      (bus),
        .tag_err_o(tagErr)
    );

    always #5 cpu_clk_g = ~cpu_clk_g;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [27:0] rndAddr();
        return 28'($urandom);
    endfunction

    function automatic logic [255:0] rndWide();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected behaviour for the current cycle's inputs, then advance the model
    task automatic modelCycle();
        int           who = 0;
        bit           expAf = 0, expWdf = 0, expPxV = 0, expCV = 0;
        bit           popNow = 0, pushNow = 0, pushTag = 0;
        bit           readOk, writeOk, pxE, cE, gE;
        logic [30:0]  expAddr = '0;
        logic [127:0] expDin = '0;
        logic [15:0]  expMask = '0;
        if (!rst) begin
            readOk  = !bus.af_full && (tagQ.size() < TAG_DEPTH);
            writeOk = !bus.af_full && !bus.wdf_full;
            pxE = bus.px_req && readOk;
            cE  = bus.c_req && (bus.c_we ? writeOk : readOk);
            gE  = bus.g_req && writeOk;
            if (wr2M) begin
                expWdf  = !bus.wdf_full;
                expDin  = upperM;
                expMask = upperMaskM;
            end else if (waitM >= STARVE_LIMIT && gE) who = 3;
            else if (pxE) who = 1;
            else if (cE)  who = 2;
            else if (gE)  who = 3;
            if (who == 1) begin
                expAf = 1; expAddr = {3'b001, bus.px_addr}; pushNow = 1; pushTag = 0;
            end
            if (who == 2 && !bus.c_we) begin
                expAf = 1; expAddr = {3'b001, bus.c_addr}; pushNow = 1; pushTag = 1;
            end
            if (who == 2 && bus.c_we) begin
                expAf = 1; expAddr = {3'b000, bus.c_addr}; expWdf = 1;
                expDin = bus.c_din[127:0]; expMask = bus.c_mask[15:0];
            end
            if (who == 3) begin
                expAf = 1; expAddr = {3'b000, bus.g_addr}; expWdf = 1;
                expDin = bus.g_din[127:0]; expMask = bus.g_mask[15:0];
            end
            if (bus.rdf_valid && tagQ.size() > 0) begin
                expPxV = (tagQ[0] == 1'b0);
                expCV  = (tagQ[0] == 1'b1);
                popNow = beatM;
            end
        end
        checkOutput("px_ack", 256'(bus.px_ack), 256'(who == 1));
        checkOutput("c_ack", 256'(bus.c_ack), 256'(who == 2));
        checkOutput("g_ack", 256'(bus.g_ack), 256'(who == 3));
        checkOutput("af_wr_en", 256'(bus.af_wr_en), 256'(expAf));
        checkOutput("wdf_wr_en", 256'(bus.wdf_wr_en), 256'(expWdf));
        checkOutput("px_rd_valid", 256'(bus.px_rd_valid), 256'(expPxV));
        checkOutput("c_rd_valid", 256'(bus.c_rd_valid), 256'(expCV));
        checkOutput("rd_data", 256'(bus.rd_data), 256'(bus.rdf_dout));
        if (expAf)  checkOutput("af_addr_din", 256'(bus.af_addr_din), 256'(expAddr));
        if (expWdf) checkOutput("wdf_din", 256'(bus.wdf_din), 256'(expDin));
        if (expWdf) checkOutput("wdf_mask_din", 256'(bus.wdf_mask_din), 256'(expMask));
        if (!rst)   checkOutput("tag_err", 256'(tagErr), 256'(errM));

        ackWho  = bus.px_ack ? 1 : bus.c_ack ? 2 : bus.g_ack ? 3 : 0;
        lastAf  = bus.af_wr_en;
        lastWdf = bus.wdf_wr_en;
        lastPxV = bus.px_rd_valid;
        lastCV  = bus.c_rd_valid;

        if (rst) begin
            tagQ.delete();
            beatM = 0; wr2M = 0; errM = 0; waitM = 0;
        end else begin
            if (wr2M && !bus.wdf_full) wr2M = 0;
            if (who == 2 && bus.c_we) begin
                wr2M = 1; upperM = bus.c_din[255:128]; upperMaskM = bus.c_mask[31:16];
            end
            if (who == 3) begin
                wr2M = 1; upperM = bus.g_din[255:128]; upperMaskM = bus.g_mask[31:16];
            end
            if (bus.rdf_valid) begin
                if (tagQ.size() == 0) errM = 1;
                else beatM = !beatM;
            end
            if (popNow)  void'(tagQ.pop_front());
            if (pushNow) tagQ.push_back(pushTag);
            if (bus.g_req && who != 3) begin
                if (waitM < 63) waitM++;
            end else waitM = 0;
        end
    endtask

    // One clock: check at the falling edge, then let requesters react to their acks
    task automatic applyStimulus();
        @(negedge cpu_clk_g);
        modelCycle();
        @(posedge cpu_clk_g);
        #1;
        if (ackWho == 1) begin bus.px_req = pxAgain; bus.px_addr = rndAddr(); end
        if (ackWho == 2) begin
            bus.c_req = cAgain; bus.c_addr = rndAddr();
            bus.c_din = rndWide(); bus.c_mask = 32'($urandom);
        end
        if (ackWho == 3) begin
            bus.g_req = gAgain; bus.g_addr = rndAddr();
            bus.g_din = rndWide(); bus.g_mask = 32'($urandom);
        end
    endtask

    task automatic doReset();
        pxAgain = 0; cAgain = 0; gAgain = 0;
        bus.px_req = 0; bus.c_req = 0; bus.g_req = 0; bus.c_we = 0;
        bus.af_full = 0; bus.wdf_full = 0; bus.rdf_valid = 0;
        rst = 1;
        applyStimulus();
        applyStimulus();
        rst = 0;
    endtask

    initial begin
        int expSeq[4];
        int gotAt;
        int n;
        rst = 1;
        bus.px_req = 0; bus.px_addr = rndAddr();
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = rndAddr(); bus.c_din = rndWide(); bus.c_mask = 32'($urandom);
        bus.g_req = 0; bus.g_addr = rndAddr(); bus.g_din = rndWide(); bus.g_mask = 32'($urandom);
        bus.af_full = 0; bus.wdf_full = 0; bus.rdf_valid = 0; bus.rdf_dout = rndWide()[127:0];

        // Reset state
        doReset();
        checkOutput("reset_err", 256'(tagErr), 256'(0));

        // All three pending: px read, c write, its second beat, then gfx
        bus.px_req = 1; bus.c_req = 1; bus.c_we = 1; bus.g_req = 1;
        expSeq = '{1, 2, 0, 3};
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("order%0d", i), 256'(ackWho), 256'(expSeq[i]));
            if (i == 2) checkOutput("order_wr2_beat", 256'(lastWdf), 256'(1));
        end

        // Write with wdf_full held for three cycles after the grant
        doReset();
        bus.c_req = 1; bus.c_we = 1;
        applyStimulus();
        checkOutput("wfull_grant", 256'(ackWho), 256'(2));
        bus.wdf_full = 1; bus.px_req = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("wfull_hold_wdf", 256'(lastWdf), 256'(0));
            checkOutput("wfull_hold_af", 256'(lastAf), 256'(0));
        end
        bus.wdf_full = 0;
        applyStimulus();
        checkOutput("wfull_release_wdf", 256'(lastWdf), 256'(1));
        checkOutput("wfull_release_af", 256'(lastAf), 256'(0));
        applyStimulus();
        checkOutput("wfull_then_px", 256'(ackWho), 256'(1));

        // Continuous px reads must not starve gfx beyond the limit
        doReset();
        pxAgain = 1; bus.px_req = 1; bus.g_req = 1; bus.rdf_valid = 1;
        gotAt = -1;
        for (int i = 0; i <= STARVE_LIMIT + 1 && gotAt < 0; i++) begin
            bus.rdf_dout = rndWide()[127:0];
            applyStimulus();
            if (ackWho == 3) gotAt = i;
        end
        checkOutput("starve_bound", 256'(gotAt >= 0 && gotAt <= STARVE_LIMIT + 1), 256'(1));

        // Tag FIFO full after 16 reads: the next read waits for a tag to retire
        doReset();
        pxAgain = 1; bus.px_req = 1; n = 0;
        for (int i = 0; i < TAG_DEPTH; i++) begin
            applyStimulus();
            if (ackWho == 1) n++;
        end
        checkOutput("fill_count", 256'(n), 256'(TAG_DEPTH));
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("full_stall", 256'(ackWho), 256'(0));
        end
        bus.rdf_valid = 1; bus.rdf_dout = rndWide()[127:0];
        applyStimulus();
        checkOutput("full_beat1_ack", 256'(ackWho), 256'(0));
        checkOutput("full_beat1_pxv", 256'(lastPxV), 256'(1));
        bus.rdf_dout = rndWide()[127:0];
        applyStimulus();
        checkOutput("full_beat2_ack", 256'(ackWho), 256'(0));
        bus.rdf_valid = 0; pxAgain = 0;
        applyStimulus();
        checkOutput("full_after_pop", 256'(ackWho), 256'(1));

        // px read then c read; four return beats split px,px,c,c
        doReset();
        bus.px_req = 1;
        applyStimulus();
        bus.c_req = 1; bus.c_we = 0;
        applyStimulus();
        checkOutput("route_c_ack", 256'(ackWho), 256'(2));
        bus.rdf_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.rdf_dout = rndWide()[127:0];
            applyStimulus();
            checkOutput($sformatf("route_px%0d", i), 256'(lastPxV), 256'(i < 2));
            checkOutput($sformatf("route_c%0d", i), 256'(lastCV), 256'(i >= 2));
        end
        bus.rdf_valid = 0;

        // af_full blocks everything; grant on the first free cycle
        doReset();
        bus.af_full = 1; bus.px_req = 1; bus.c_req = 1; bus.c_we = 1; bus.g_req = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("affull_ack", 256'(ackWho), 256'(0));
            checkOutput("affull_en", 256'(lastAf), 256'(0));
        end
        bus.af_full = 0;
        applyStimulus();
        checkOutput("affull_release", 256'(ackWho), 256'(1));
        checkOutput("affull_release_en", 256'(lastAf), 256'(1));

        // Reset while the upper beat is pending drops it
        doReset();
        bus.c_req = 1; bus.c_we = 1;
        applyStimulus();
        bus.wdf_full = 1;
        applyStimulus();
        rst = 1;
        applyStimulus();
        checkOutput("rst_wr2_wdf", 256'(lastWdf), 256'(0));
        rst = 0; bus.wdf_full = 0;
        applyStimulus();
        checkOutput("rst_wr2_abandon", 256'(lastWdf), 256'(0));

        // Reset with a read outstanding: the late return is dropped and flagged
        doReset();
        bus.px_req = 1;
        applyStimulus();
        rst = 1;
        applyStimulus();
        rst = 0; bus.rdf_valid = 1;
        applyStimulus();
        checkOutput("stale_pxv", 256'(lastPxV), 256'(0));
        bus.rdf_valid = 0;
        applyStimulus();
        checkOutput("stale_err", 256'(tagErr), 256'(1));
        applyStimulus();
        checkOutput("stale_err_sticky", 256'(tagErr), 256'(1));

        // Random traffic against the model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            if (!bus.px_req && ($urandom % 3 == 0)) begin
                bus.px_req = 1; bus.px_addr = rndAddr();
            end
            if (!bus.c_req && ($urandom % 3 == 0)) begin
                bus.c_req = 1; bus.c_we = 1'($urandom % 2); bus.c_addr = rndAddr();
                bus.c_din = rndWide(); bus.c_mask = 32'($urandom);
            end
            if (!bus.g_req && ($urandom % 4 == 0)) begin
                bus.g_req = 1; bus.g_addr = rndAddr();
                bus.g_din = rndWide(); bus.g_mask = 32'($urandom);
            end
            bus.af_full   = ($urandom % 5 == 0);
            bus.wdf_full  = ($urandom % 4 == 0);
            bus.rdf_valid = ($urandom % 3 == 0);
            bus.rdf_dout  = rndWide()[127:0];
            rst           = ($urandom % 200 == 0);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
